// File: rtl/exram_pkg.sv
// EXRAM memory map shared by mem_cpu and the port B arbiter.
// Constants and small types only; no ports.
package exram_pkg;

   localparam int EXRAM_ADDR_W = 16;
   localparam int EXRAM_DATA_W = 16;

   localparam logic [15:0] INSTRUCTION_MEM = 16'h0000;
   localparam logic [15:0] DATA_STACK      = 16'hC000;
   localparam logic [15:0] IO_MEM          = 16'hCFFD;
   localparam logic [15:0] SWITCHES_LOC    = 16'hCFFE;
   localparam logic [15:0] LEDS_LOC        = 16'hCFFF;

   localparam int BURST_W = 8;
   typedef logic [BURST_W-1:0] burst_cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, modulo NREQ.
// Ports: ptr, req in; gnt_oh (one-hot), idx, any out. Combinational.
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [$clog2(NREQ)-1:0] ptr,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         gnt_oh,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int PW = $clog2(NREQ);
   localparam logic [PW:0] N_W = (PW+1)'(NREQ);

   logic [PW:0] cand;

   // Scan offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      idx  = '0;
      cand = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (PW+1)'(i);
         if (cand >= N_W) cand = cand - N_W;
         if (req[cand[PW-1:0]]) idx = cand[PW-1:0];
      end
      any    = |req;
      gnt_oh = '0;
      for (int k = 0; k < NREQ; k++) begin
         gnt_oh[k] = any && (idx == PW'(k));
      end
   end

endmodule

// File: rtl/exram_portb_arbiter.sv
// Round-robin arbiter driving EXRAM port B for NREQ requesters,
// with lockable bursts (bounded by MAX_BURST) and IO-window write filter.
// Ports: clk, reset (sync, active high); req/lock/we/addr/wdata per
// requester; gnt, rvalid, rdata, wr_blocked back to requesters;
// mem_addr/mem_data/mem_wren to EXRAM port B, mem_q from it.
module exram_portb_arbiter
   import exram_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int ADDR_W    = EXRAM_ADDR_W,
   parameter int DATA_W    = EXRAM_DATA_W,
   parameter logic [ADDR_W-1:0] IO_MEM = ADDR_W'(exram_pkg::IO_MEM),
   parameter int MAX_BURST = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          lock,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*ADDR_W-1:0]   addr,
   input  logic [NREQ*DATA_W-1:0]   wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic                     wr_blocked,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_data,
   output logic                     mem_wren,
   input  logic [DATA_W-1:0]        mem_q
);

   localparam int PW = $clog2(NREQ);
   localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
   localparam burst_cnt_t MAX_B = burst_cnt_t'(MAX_BURST);

   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic            owner_valid_q, owner_valid_d;
   burst_cnt_t      burst_cnt_q, burst_cnt_d;
   logic [NREQ-1:0] rvalid_q, rvalid_d;
   logic            wr_blocked_q, wr_blocked_d;

   logic [ADDR_W-1:0] addr_a  [NREQ];
   logic [DATA_W-1:0] wdata_a [NREQ];

   logic [NREQ-1:0] rr_oh, owner_oh;
   logic [PW-1:0]   rr_idx, winner;
   logic            rr_any, hold, gnt_any;
   logic            win_we, win_io;
   logic [ADDR_W-1:0] win_addr;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .ptr    (ptr_q),
      .req    (req),
      .gnt_oh (rr_oh),
      .idx    (rr_idx),
      .any    (rr_any)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
         wdata_a[i] = wdata[i*DATA_W +: DATA_W];
         owner_oh[i] = (owner_q == PW'(i));
      end
   end

   // Arbitration and memory drive.
   always_comb begin
      hold = owner_valid_q & req[owner_q] & lock[owner_q]
           & (burst_cnt_q < MAX_B);
      gnt_any  = rr_any & ~reset;
      winner   = hold ? owner_q : rr_idx;
      win_we   = we[winner];
      win_addr = addr_a[winner];
      win_io   = (win_addr >= IO_MEM);

      gnt      = '0;
      mem_addr = '0;
      mem_data = '0;
      mem_wren = 1'b0;
      if (gnt_any) begin
         gnt      = hold ? owner_oh : rr_oh;
         mem_addr = win_addr;
         mem_data = wdata_a[winner];
         mem_wren = win_we & ~win_io;
      end
   end

   // Next state.
   always_comb begin
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      burst_cnt_d   = burst_cnt_q;
      rvalid_d      = gnt & ~we;
      wr_blocked_d  = gnt_any & win_we & win_io;
      if (gnt_any) begin
         ptr_d         = (winner == LAST) ? '0 : winner + 1'b1;
         owner_d       = winner;
         owner_valid_d = lock[winner];
         if ((winner == owner_q) && owner_valid_q) begin
            // Saturate so a long sole-requester run never re-arms the lock.
            burst_cnt_d = (burst_cnt_q == '1) ? burst_cnt_q
                                              : burst_cnt_q + 8'd1;
         end else begin
            burst_cnt_d = 8'd1;
         end
      end else begin
         owner_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q         <= '0;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         burst_cnt_q   <= '0;
         rvalid_q      <= '0;
         wr_blocked_q  <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         burst_cnt_q   <= burst_cnt_d;
         rvalid_q      <= rvalid_d;
         wr_blocked_q  <= wr_blocked_d;
      end
   end

   // Responses are masked during reset so an access granted just before
   // reset never reports completion.
   assign rvalid     = rvalid_q & {NREQ{~reset}};
   assign wr_blocked = wr_blocked_q & ~reset;
   assign rdata      = mem_q;

endmodule

// File: tb/tb_exram_portb_arbiter.sv
// Bench for exram_portb_arbiter: EXRAM model, behavioural reference,
// directed scenarios and randomized traffic.
module tb_exram_portb_arbiter;

   localparam int NREQ = 4;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int MAXB = 8;
   localparam logic [15:0] IO = 16'hCFFD;

   logic clk = 1'b0;
   logic reset;
   logic [NREQ-1:0] req, lock, we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0] gnt, rvalid;
   logic [DW-1:0] rdata, mem_data, mem_q;
   logic wr_blocked, mem_wren;
   logic [AW-1:0] mem_addr;

   always #10 clk = ~clk;

   exram_portb_arbiter #(
      .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW),
      .IO_MEM(IO), .MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .wr_blocked(wr_blocked), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   // EXRAM port B: synchronous read, 1-cycle latency.
   logic [15:0] ram [65536];
   logic [15:0] q_r;
   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      q_r <= ram[mem_addr];
   end
   assign mem_q = q_r;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model state.
   logic [15:0] shadow [65536];
   int m_ptr = 0, m_owner = 0, m_cnt = 0, m_last_w = -1;
   bit m_ov = 0;
   logic [NREQ-1:0] e_rvalid = '0;
   logic [15:0] e_rdata = '0;
   bit e_wrb = 0;
   bit chk_en = 0;

   function automatic logic [15:0] get_addr(int w);
      return addr[w*AW +: AW];
   endfunction

   function automatic logic [15:0] get_wdata(int w);
      return wdata[w*DW +: DW];
   endfunction

   function automatic int m_pick();
      if (reset || req == '0) return -1;
      if (m_ov && req[m_owner] && lock[m_owner] && m_cnt < MAXB)
         return m_owner;
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (m_ptr + k) % NREQ;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      int w;
      logic [15:0] a;
      w = m_pick();
      if (reset) begin
         m_ptr <= 0; m_ov <= 0; m_cnt <= 0;
         e_rvalid <= '0; e_wrb <= 0;
      end else if (w < 0) begin
         m_ov <= 0; e_rvalid <= '0; e_wrb <= 0;
      end else begin
         a = get_addr(w);
         e_rvalid <= we[w] ? '0 : NREQ'(1 << w);
         e_rdata <= shadow[a];
         e_wrb <= we[w] && (a >= IO);
         if (we[w] && a < IO) shadow[a] <= get_wdata(w);
         if (w == m_owner && m_ov)
            m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
         else
            m_cnt <= 1;
         m_owner <= w;
         m_ov <= lock[w];
         m_ptr <= (w + 1) % NREQ;
      end
      m_last_w <= w;
   end

   always @(negedge clk) begin : compare
      int w;
      logic [NREQ-1:0] eg;
      logic [15:0] ea, ed;
      logic ew;
      if (chk_en) begin
         w = m_pick();
         eg = '0; ea = '0; ed = '0; ew = 1'b0;
         if (w >= 0) begin
            eg[w] = 1'b1;
            ea = get_addr(w);
            ed = get_wdata(w);
            ew = we[w] && (ea < IO);
         end
         cmp("gnt", 32'(gnt), 32'(eg));
         cmp("mem_addr", 32'(mem_addr), 32'(ea));
         cmp("mem_data", 32'(mem_data), 32'(ed));
         cmp("mem_wren", 32'(mem_wren), 32'(ew));
         cmp("rvalid", 32'(rvalid), reset ? 32'd0 : 32'(e_rvalid));
         cmp("wr_blocked", 32'(wr_blocked), reset ? 32'd0 : 32'(e_wrb));
         if (!reset && e_rvalid != '0)
            cmp("rdata", 32'(rdata), 32'(e_rdata));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = '0; lock = '0; we = '0;
      look();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_rq(int i, logic w, logic [15:0] a, logic [15:0] d);
      we[i] = w;
      addr[i*AW +: AW] = a;
      wdata[i*DW +: DW] = d;
   endtask

   function automatic logic [15:0] rnd_addr();
      case ($urandom_range(0, 3))
         0: return 16'h0010 + 16'($urandom_range(0, 7));
         1: return 16'h0100;
         2: return 16'hCFFB + 16'($urandom_range(0, 4));
         default: return 16'($urandom);
      endcase
   endfunction

   int burst_seq [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 4, 1};

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i] = 16'(i) ^ 16'h5A5A;
         shadow[i] = 16'(i) ^ 16'h5A5A;
      end
      ram[16'h0010] = 16'hBEEF;
      shadow[16'h0010] = 16'hBEEF;

      reset = 1'b1;
      req = 4'b1111; lock = '0; we = '0; addr = '0; wdata = '0;
      for (int i = 0; i < NREQ; i++) set_rq(i, 1'b0, 16'h0020 + 16'(i), '0);
      chk_en = 1;

      // Reset holds everything off, then plain rotation.
      repeat (2) begin
         look();
         cmp("rst_gnt", 32'(gnt), 32'd0);
         cmp("rst_wren", 32'(mem_wren), 32'd0);
         tick();
      end
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         look();
         cmp("rot_gnt", 32'(gnt), 32'(1 << (k % 4)));
         tick();
      end
      req = '0;

      // Single read returns next cycle.
      req = 4'b0010;
      set_rq(1, 1'b0, 16'h0010, '0);
      look();
      cmp("rd_gnt", 32'(gnt), 32'h2);
      tick();
      req = '0;
      look();
      cmp("rd_rvalid", 32'(rvalid), 32'h2);
      cmp("rd_rdata", 32'(rdata), 32'hBEEF);
      tick();

      // Locked burst bounded by MAX_BURST.
      do_reset();
      req = 4'b0101; lock = 4'b0001;
      set_rq(0, 1'b0, 16'h6000, '0);
      set_rq(2, 1'b0, 16'h0020, '0);
      for (int k = 0; k < 10; k++) begin
         look();
         cmp("burst_gnt", 32'(gnt), 32'(burst_seq[k]));
         tick();
      end
      req = '0; lock = '0;
      look();
      tick();

      // Write into IO window is filtered.
      req = 4'b1000;
      set_rq(3, 1'b1, 16'hCFFE, 16'h1234);
      look();
      cmp("io_gnt", 32'(gnt), 32'h8);
      cmp("io_wren", 32'(mem_wren), 32'd0);
      tick();
      set_rq(3, 1'b0, 16'hCFFE, '0);
      look();
      cmp("io_wrb", 32'(wr_blocked), 32'd1);
      tick();
      req = '0;
      look();
      cmp("io_rvalid", 32'(rvalid), 32'h8);
      cmp("io_rdata", 32'(rdata), 32'h95A4);
      tick();

      // Write then read-back from another requester.
      req = 4'b0100;
      set_rq(2, 1'b1, 16'h0100, 16'hA5A5);
      look();
      cmp("wr_gnt", 32'(gnt), 32'h4);
      cmp("wr_wren", 32'(mem_wren), 32'd1);
      tick();
      req = 4'b0010; we = '0;
      set_rq(1, 1'b0, 16'h0100, '0);
      look();
      cmp("rb_gnt", 32'(gnt), 32'h2);
      tick();
      req = '0;
      look();
      cmp("rb_rvalid", 32'(rvalid), 32'h2);
      cmp("rb_rdata", 32'(rdata), 32'hA5A5);
      tick();

      // Reset right after a read grant cancels the response.
      req = 4'b0001;
      set_rq(0, 1'b0, 16'h0011, '0);
      look();
      cmp("rr_gnt", 32'(gnt), 32'h1);
      tick();
      reset = 1'b1; req = '0;
      look();
      cmp("rr_rvalid", 32'(rvalid), 32'd0);
      tick();
      reset = 1'b0;
      req = 4'b0011;
      set_rq(1, 1'b0, 16'h0012, '0);
      look();
      cmp("rr_rvalid2", 32'(rvalid), 32'd0);
      cmp("rr_first", 32'(gnt), 32'h1);
      tick();
      req = '0;
      look();
      tick();

      // Random traffic; pending requests stay untouched until granted.
      for (int c = 0; c < 800; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || m_last_w == i) begin
               req[i] = ($urandom_range(0, 2) != 0);
               set_rq(i, ($urandom_range(0, 3) == 0), rnd_addr(),
                      16'($urandom));
            end
         end
         lock = NREQ'($urandom | $urandom);
         tick();
      end
      reset = 1'b0; req = '0; lock = '0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/exram_portb_arbiter.md
Name: exram_portb_arbiter

Overview:
- Shares EXRAM port B between NREQ on-chip requesters, e.g. a 7-seg/LED refresher, switch poller and DMA engine.
- Port B is currently tied off; this block drives it.
- Grants are round-robin, one access per clock. Bursts are allowed via a lock bit, bounded by MAX_BURST.
- Writes into the IO window are filtered the same way port A is.
- Read data returns with the EXRAM's fixed 1-cycle synchronous-read latency.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- IO_MEM, 16'hCFFD, base of the IO window; addresses >= IO_MEM are write-protected.
- MAX_BURST, 8, maximum consecutive grants to one locked requester (1..255).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester access request, level, held until granted
- lock  in  NREQ  per-requester burst hold; meaningful only while req is high
- we  in  NREQ  per-requester write enable (0 = read)
- addr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  NREQ*DATA_W  packed write data
- gnt  out  NREQ  one-hot; high in the cycle the request is accepted
- rvalid  out  NREQ  one-hot; high 1 cycle after a read grant
- rdata  out  DATA_W  shared read data, valid when any rvalid is set
- wr_blocked  out  1  1-cycle pulse, 1 cycle after a granted write to addr >= IO_MEM
- mem_addr  out  ADDR_W  to EXRAM address_b
- mem_data  out  DATA_W  to EXRAM data_b
- mem_wren  out  1  to EXRAM wren_b
- mem_q  in  DATA_W  from EXRAM q_b

Behaviour:
- Arbitration (combinational):
  - Winner is the first requester with req=1, scanning from ptr upward modulo NREQ.
  - Exception: if owner_valid and req[owner]=1 and lock[owner]=1 and burst_cnt < MAX_BURST, the winner is the owner.
  - gnt = onehot(winner), or 0 when no req.
- Memory drive (combinational):
  - mem_addr = addr[winner]; mem_data = wdata[winner].
  - mem_wren = gnt_any & we[winner] & (addr[winner] < IO_MEM).
  - With no grant: mem_addr = 0, mem_data = 0, mem_wren = 0.
- Registered state, updated on posedge clk when a grant occurs:
  - ptr <= (winner+1) mod NREQ.
  - owner <= winner; owner_valid <= lock[winner].
  - burst_cnt <= (winner==owner && owner_valid) ? burst_cnt+1 : 1.
- Burst and idle rules:
  - When burst_cnt reaches MAX_BURST, the lock is ignored for one arbitration. The owner can still win by normal rotation, but only if it is the sole requester.
  - An idle cycle (no req) clears owner_valid and leaves ptr unchanged.
- Read return:
  - rvalid <= gnt & ~we (per bit), rdata driven from mem_q.
  - Exactly 1-cycle latency, fully pipelined: back-to-back reads from different requesters return in order, one per cycle.
- Write filter:
  - A granted write with addr >= IO_MEM still consumes its grant and asserts gnt, but mem_wren = 0.
  - wr_blocked pulses the next cycle.
  - No rvalid is produced for any write.
- Reset (synchronous, sampled on posedge):
  - ptr = 0, owner_valid = 0, burst_cnt = 0, rvalid = 0, wr_blocked = 0.
  - gnt and mem_* stay combinational but are forced to 0 while reset = 1.
  - A read granted in the cycle before reset produces no rvalid (rvalid cleared by reset).
- Simultaneous events:
  - A requester dropping req in its own grant cycle is illegal; req must be held until gnt.
  - Changing lock on a grant cycle takes effect for the next arbitration.
- Widths: burst_cnt is 8 bits; winner/ptr are $clog2(NREQ) bits; ptr wraps at NREQ, not at a power of two.

Decomposition:
- Shared package (exram_pkg): IO_MEM, SWITCHES_LOC, LEDS_LOC, INSTRUCTION_MEM, DATA_STACK, ADDR_W/DATA_W defaults. mem_cpu and this block use the same constants.
- One sub-module: rr_pick (ptr, req vector -> one-hot winner + index), purely combinational.
- Counters and state remain in the top.

Test Plan:
1. Reset held 2 cycles with req=4'b1111 -> gnt=0, mem_wren=0. After release, grants go 0,1,2,3,0 on consecutive cycles.
2. Req1 read addr 16'h0010 (RAM holds 16'hBEEF) -> gnt[1] at cycle N. At N+1: rvalid=4'b0010, rdata=16'hBEEF.
3. Req0 lock=1 reading 16'h6000..; req2 also requesting; MAX_BURST=8 -> req0 granted 8 consecutive cycles, then req2 granted, then req0 resumes.
4. Req3 write addr 16'hCFFE, data 16'h1234 -> gnt[3]=1, mem_wren=0, wr_blocked=1 next cycle. A following read of 16'hCFFE is unchanged.
5. Req2 write 16'h0100 <= 16'hA5A5, then req1 read 16'h0100 on the next cycle -> rvalid[1] with rdata=16'hA5A5.
6. Req0 read granted, reset asserted the next cycle -> no rvalid seen. ptr returns to 0: with req=4'b0011, first grant after reset is req0.
